// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB with a
// ready handshake to a variable-latency memory.
// Optional macro MEM_TIMEOUT_EN: abort a memory access that waits
// MEM_TIMEOUT cycles without mem_ready (raises except, returns to FETCH).
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_NOR 3'd5
`endif

module mips_multicycle_ctrl #(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                writeenable,
    output logic                rd_src,
    output logic                alu_src2,
    output logic                except,
    output logic [1:0]          control_type,
    output logic                mem_read,
    output logic                word_we,
    output logic                byte_we,
    output logic                byte_load,
    output logic                slt,
    output logic                lui,
    output logic                addm,
    output logic                pc_we,
    output logic                ir_we,
    output logic [2:0]          state
);

    localparam logic [5:0] OP_OTHER0 = 6'h00, OP_OTHER1 = 6'h01, OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ    = 6'h04, OP_BNE    = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0a, OP_ANDI   = 6'h0c, OP_ORI  = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e, OP_LUI    = 6'h0f, OP_LW   = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24, OP_SB     = 6'h28, OP_SW   = 6'h2b;
    localparam logic [5:0] OP0_JR    = 6'h08, OP0_ADD   = 6'h20, OP0_SUB = 6'h22;
    localparam logic [5:0] OP0_AND   = 6'h24, OP0_OR    = 6'h25, OP0_XOR = 6'h26;
    localparam logic [5:0] OP0_NOR   = 6'h27, OP0_SLT   = 6'h2a, OP0_ADDM = 6'h2c;

    localparam logic [ALU_OP_W-1:0] A_ADD = ALU_OP_W'(`ALU_ADD);
    localparam logic [ALU_OP_W-1:0] A_SUB = ALU_OP_W'(`ALU_SUB);
    localparam logic [ALU_OP_W-1:0] A_AND = ALU_OP_W'(`ALU_AND);
    localparam logic [ALU_OP_W-1:0] A_OR  = ALU_OP_W'(`ALU_OR);
    localparam logic [ALU_OP_W-1:0] A_XOR = ALU_OP_W'(`ALU_XOR);
    localparam logic [ALU_OP_W-1:0] A_NOR = ALU_OP_W'(`ALU_NOR);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
    } state_t;

    // Instruction classes; C_ILL is the reset value of the latched class.
    typedef enum logic [3:0] {
        C_ILL, C_ALU, C_ALUI, C_SLT, C_SLTI, C_LUI, C_BEQ, C_BNE,
        C_J, C_JR, C_LW, C_LBU, C_SW, C_SB, C_ADDM
    } cls_t;

    if ((1 << CNT_W) <= MEM_TIMEOUT) begin : g_cfg_check
        $error("CNT_W too narrow for MEM_TIMEOUT");
    end

    state_t              st, st_nx;
    cls_t                cls_dec, cls_q;
    logic [ALU_OP_W-1:0] aop_dec, aop_q;
    logic                run;
    logic                timeout;
    logic                in_wait;

    assign in_wait = run && (st == S_FETCH || st == S_MEM) && !mem_ready;

    // Classify the live opcode/funct (meaningful while in DECODE).
    always_comb begin
        cls_dec = C_ILL;
        aop_dec = A_ADD;
        case (opcode)
            OP_OTHER0: begin
                case (funct)
                    OP0_ADD:  cls_dec = C_ALU;
                    OP0_SUB:  begin cls_dec = C_ALU; aop_dec = A_SUB; end
                    OP0_AND:  begin cls_dec = C_ALU; aop_dec = A_AND; end
                    OP0_OR:   begin cls_dec = C_ALU; aop_dec = A_OR;  end
                    OP0_XOR:  begin cls_dec = C_ALU; aop_dec = A_XOR; end
                    OP0_NOR:  begin cls_dec = C_ALU; aop_dec = A_NOR; end
                    OP0_SLT:  begin cls_dec = C_SLT; aop_dec = A_SUB; end
                    OP0_JR:   cls_dec = C_JR;
                    OP0_ADDM: cls_dec = C_ADDM;
                    default:  cls_dec = C_ILL;
                endcase
            end
            OP_J:    cls_dec = C_J;
            OP_BEQ:  begin cls_dec = C_BEQ;  aop_dec = A_SUB; end
            OP_BNE:  begin cls_dec = C_BNE;  aop_dec = A_SUB; end
            OP_ADDI: cls_dec = C_ALUI;
            OP_SLTI: begin cls_dec = C_SLTI; aop_dec = A_SUB; end
            OP_ANDI: begin cls_dec = C_ALUI; aop_dec = A_AND; end
            OP_ORI:  begin cls_dec = C_ALUI; aop_dec = A_OR;  end
            OP_XORI: begin cls_dec = C_ALUI; aop_dec = A_XOR; end
            OP_LUI:  cls_dec = C_LUI;
            OP_LW:   cls_dec = C_LW;
            OP_LBU:  cls_dec = C_LBU;
            OP_SW:   cls_dec = C_SW;
            OP_SB:   cls_dec = C_SB;
            default: cls_dec = C_ILL;
        endcase
    end

    // State register; run gates every output so the cycle after reset release is idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st  <= S_FETCH;
            run <= 1'b0;
        end else begin
            st  <= st_nx;
            run <= 1'b1;
        end
    end

    // Latch the decode at the DECODE->EXEC edge so the IR may change afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cls_q <= C_ILL;
            aop_q <= A_ADD;
        end else if (run && st == S_DECODE) begin
            cls_q <= cls_dec;
            aop_q <= aop_dec;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic [CNT_W-1:0] wait_cnt;

    // Wait counter: cleared on every state entry, saturating while waiting on memory.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (!run || st_nx != st || timeout) begin
            wait_cnt <= '0;
        end else if (in_wait && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout = in_wait && (wait_cnt >= CNT_W'(MEM_TIMEOUT));
`else
    assign timeout = 1'b0;
`endif

    // Next-state and control outputs from the current state and latched decode.
    always_comb begin
        st_nx        = st;
        alu_op       = '0;
        writeenable  = 1'b0;
        rd_src       = 1'b0;
        alu_src2     = 1'b0;
        except       = 1'b0;
        control_type = 2'd0;
        mem_read     = 1'b0;
        word_we      = 1'b0;
        byte_we      = 1'b0;
        byte_load    = 1'b0;
        slt          = 1'b0;
        lui          = 1'b0;
        addm         = 1'b0;
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        if (run) begin
            case (st)
                S_FETCH: begin
                    if (timeout) begin
                        except = 1'b1;
                        pc_we  = 1'b1;
                    end else begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            ir_we = 1'b1;
                            st_nx = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (cls_dec == C_ILL) begin
                        except = 1'b1;
                        pc_we  = 1'b1;
                        st_nx  = S_FETCH;
                    end else begin
                        st_nx = S_EXEC;
                    end
                end
                S_EXEC: begin
                    alu_op   = aop_q;
                    alu_src2 = cls_q inside {C_ALUI, C_SLTI, C_LUI, C_LW, C_LBU, C_SW, C_SB};
                    st_nx    = S_WB;
                    if (cls_q == C_BEQ || cls_q == C_BNE) begin
                        pc_we = 1'b1;
                        control_type = ((cls_q == C_BEQ && zero) || (cls_q == C_BNE && !zero))
                                       ? 2'd1 : 2'd0;
                        st_nx = S_FETCH;
                    end else if (cls_q == C_J || cls_q == C_JR) begin
                        pc_we        = 1'b1;
                        control_type = (cls_q == C_J) ? 2'd2 : 2'd3;
                        st_nx        = S_FETCH;
                    end else if (cls_q inside {C_LW, C_LBU, C_SW, C_SB, C_ADDM}) begin
                        st_nx = S_MEM;
                    end
                end
                S_MEM: begin
                    if (timeout) begin
                        except = 1'b1;
                        pc_we  = 1'b1;
                        st_nx  = S_FETCH;
                    end else begin
                        mem_read  = cls_q inside {C_LW, C_LBU, C_ADDM};
                        word_we   = (cls_q == C_SW);
                        byte_we   = (cls_q == C_SB);
                        byte_load = (cls_q == C_LBU);
                        if (mem_ready) begin
                            if (cls_q == C_SW || cls_q == C_SB) begin
                                pc_we = 1'b1;
                                st_nx = S_FETCH;
                            end else begin
                                st_nx = S_WB;
                            end
                        end
                    end
                end
                S_WB: begin
                    writeenable = 1'b1;
                    pc_we       = 1'b1;
                    rd_src      = cls_q inside {C_ALU, C_SLT, C_ADDM};
                    slt         = cls_q inside {C_SLT, C_SLTI};
                    lui         = (cls_q == C_LUI);
                    addm        = (cls_q == C_ADDM);
                    byte_load   = (cls_q == C_LBU);
                    st_nx       = S_FETCH;
                end
                default: st_nx = S_FETCH;
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed vector table,
// randomized instruction stream against a phase-level reference model,
// plus hand sequences for memory timeout/hang and asynchronous reset.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R = 6'h00, OP_ILL1 = 6'h01, OP_J = 6'h02, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0a, OP_ANDI = 6'h0c;
    localparam logic [5:0] OP_ORI = 6'h0d, OP_XORI = 6'h0e, OP_LUI = 6'h0f, OP_LW = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24, OP_SB = 6'h28, OP_SW = 6'h2b;
    localparam logic [5:0] F_JR = 6'h08, F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24;
    localparam logic [5:0] F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27, F_SLT = 6'h2a, F_ADDM = 6'h2c;
    localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_AND = 3'd2, A_OR = 3'd3, A_XOR = 3'd4, A_NOR = 3'd5;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic [2:0] alu_op;
    logic       writeenable, rd_src, alu_src2, except;
    logic [1:0] control_type;
    logic       mem_read, word_we, byte_we, byte_load, slt, lui, addm, pc_we, ir_we;
    logic [2:0] state;

    mips_multicycle_ctrl #(.ALU_OP_W(3), .MEM_TIMEOUT(4), .CNT_W(5)) dut (
        .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .writeenable(writeenable), .rd_src(rd_src),
        .alu_src2(alu_src2), .except(except), .control_type(control_type),
        .mem_read(mem_read), .word_we(word_we), .byte_we(byte_we), .byte_load(byte_load),
        .slt(slt), .lui(lui), .addm(addm), .pc_we(pc_we), .ir_we(ir_we), .state(state)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       writeenable, rd_src, alu_src2, except;
        logic [1:0] control_type;
        logic       mem_read, word_we, byte_we, byte_load, slt, lui, addm, pc_we, ir_we;
        logic [2:0] state;
    } out_t;

    out_t act;
    assign act = {alu_op, writeenable, rd_src, alu_src2, except, control_type, mem_read,
                  word_we, byte_we, byte_load, slt, lui, addm, pc_we, ir_we, state};

    // What the instruction means, straight from the instruction-set rules.
    typedef struct {
        bit legal, wb, mem, rd, store, byt, branch, bne, src2, rd_src, slt, lui, addm, bload;
        bit [1:0] jct;
        bit [2:0] aop;
    } info_t;

    typedef struct {
        string      nm;
        logic [5:0] op, fn;
        bit         z;
        int         flat, mlat, cyc, we, exc, ct;
    } vec_t;

    int n_cmp = 0, n_bad = 0;
    int cyc, wes, excs, ct;

    function automatic info_t classify(input logic [5:0] op, input logic [5:0] fn);
        info_t d = '{default: 0};
        d.legal = 1; d.aop = A_ADD;
        case (op)
            OP_R: case (fn)
                F_ADD:  begin d.wb = 1; d.rd_src = 1; end
                F_SUB:  begin d.wb = 1; d.rd_src = 1; d.aop = A_SUB; end
                F_AND:  begin d.wb = 1; d.rd_src = 1; d.aop = A_AND; end
                F_OR:   begin d.wb = 1; d.rd_src = 1; d.aop = A_OR;  end
                F_XOR:  begin d.wb = 1; d.rd_src = 1; d.aop = A_XOR; end
                F_NOR:  begin d.wb = 1; d.rd_src = 1; d.aop = A_NOR; end
                F_SLT:  begin d.wb = 1; d.rd_src = 1; d.slt = 1; d.aop = A_SUB; end
                F_JR:   d.jct = 2'd3;
                F_ADDM: begin d.wb = 1; d.mem = 1; d.rd = 1; d.rd_src = 1; d.addm = 1; end
                default: d.legal = 0;
            endcase
            OP_J:    d.jct = 2'd2;
            OP_BEQ:  begin d.branch = 1; d.aop = A_SUB; end
            OP_BNE:  begin d.branch = 1; d.bne = 1; d.aop = A_SUB; end
            OP_ADDI: begin d.wb = 1; d.src2 = 1; end
            OP_SLTI: begin d.wb = 1; d.src2 = 1; d.slt = 1; d.aop = A_SUB; end
            OP_ANDI: begin d.wb = 1; d.src2 = 1; d.aop = A_AND; end
            OP_ORI:  begin d.wb = 1; d.src2 = 1; d.aop = A_OR; end
            OP_XORI: begin d.wb = 1; d.src2 = 1; d.aop = A_XOR; end
            OP_LUI:  begin d.wb = 1; d.src2 = 1; d.lui = 1; end
            OP_LW:   begin d.wb = 1; d.mem = 1; d.rd = 1; d.src2 = 1; end
            OP_LBU:  begin d.wb = 1; d.mem = 1; d.rd = 1; d.src2 = 1; d.bload = 1; end
            OP_SW:   begin d.mem = 1; d.store = 1; d.src2 = 1; end
            OP_SB:   begin d.mem = 1; d.store = 1; d.byt = 1; d.src2 = 1; end
            default: d.legal = 0;
        endcase
        return d;
    endfunction

    task automatic chk_int(input string nm, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, req);
        end
    endtask

    task automatic chk_out(input string nm, input out_t e);
        n_cmp++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, act, e, $time);
        end
    endtask

    // Called at a falling edge with inputs already driven: check, tally, advance one cycle.
    task automatic step(input out_t e, input string nm);
        #1;
        chk_out(nm, e);
        cyc++;
        if (act.writeenable) wes++;
        if (act.except) excs++;
        if (act.pc_we) ct = int'(act.control_type);
        @(negedge clock);
    endtask

    // Runs one instruction from its first FETCH cycle to its PC update.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit z,
                             input int flat, input int mlat);
        info_t d;
        out_t  e;
        d = classify(op, fn);
        cyc = 0; wes = 0; excs = 0; ct = -1;
        opcode = op; funct = fn; zero = z;
        for (int i = 0; i <= flat; i++) begin
            mem_ready = (i == flat);
            e = '0; e.mem_read = 1; e.ir_we = (i == flat);
            step(e, "fetch");
        end
        mem_ready = 1'($urandom);
        e = '0; e.state = 3'd1;
        if (!d.legal) begin
            e.except = 1; e.pc_we = 1;
            step(e, "decode_illegal");
            return;
        end
        step(e, "decode");
        opcode = 6'($urandom); funct = 6'($urandom); mem_ready = 1'($urandom);
        e = '0; e.state = 3'd2; e.alu_op = d.aop; e.alu_src2 = d.src2;
        if (d.branch) begin
            e.pc_we = 1; e.control_type = ((d.bne ? !z : z) ? 2'd1 : 2'd0);
        end else if (d.jct != 0) begin
            e.pc_we = 1; e.control_type = d.jct;
        end
        step(e, "exec");
        zero = 1'($urandom);
        if (e.pc_we) return;
        if (d.mem) begin
            for (int i = 0; i <= mlat; i++) begin
                mem_ready = (i == mlat);
                e = '0; e.state = 3'd3; e.mem_read = d.rd; e.byte_load = d.bload;
                e.word_we = d.store && !d.byt; e.byte_we = d.store && d.byt;
                e.pc_we = d.store && (i == mlat);
                step(e, "mem");
            end
            if (d.store) return;
        end
        mem_ready = 1'($urandom);
        e = '0; e.state = 3'd4; e.writeenable = 1; e.pc_we = 1; e.rd_src = d.rd_src;
        e.slt = d.slt; e.lui = d.lui; e.addm = d.addm; e.byte_load = d.bload;
        step(e, "wb");
    endtask

    // Release reset at a falling edge; the following cycle is idle, FETCH starts after it.
    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1; mem_ready = 1'b0;
        #1 chk_out("idle_after_reset", out_t'(0));
        @(negedge clock);
    endtask

    vec_t       tbl[13];
    logic [11:0] pool[20];
    out_t       e;

    initial begin
        tbl[0]  = '{"add",      OP_R,    F_ADD,  0, 0, 0, 4, 1, 0, 0};
        tbl[1]  = '{"beq_z1",   OP_BEQ,  6'h00,  1, 0, 0, 3, 0, 0, 1};
        tbl[2]  = '{"beq_z0",   OP_BEQ,  6'h00,  0, 0, 0, 3, 0, 0, 0};
        tbl[3]  = '{"bne_z0",   OP_BNE,  6'h00,  0, 0, 0, 3, 0, 0, 1};
        tbl[4]  = '{"j",        OP_J,    6'h00,  0, 0, 0, 3, 0, 0, 2};
        tbl[5]  = '{"jr",       OP_R,    F_JR,   0, 0, 0, 3, 0, 0, 3};
        tbl[6]  = '{"lw_d3",    OP_LW,   6'h00,  0, 0, 3, 8, 1, 0, 0};
        tbl[7]  = '{"sw_d3",    OP_SW,   6'h00,  0, 0, 3, 7, 0, 0, 0};
        tbl[8]  = '{"ill_op1",  OP_ILL1, 6'h00,  0, 0, 0, 2, 0, 1, 0};
        tbl[9]  = '{"ill_fn",   OP_R,    6'h3f,  0, 0, 0, 2, 0, 1, 0};
        tbl[10] = '{"lui_f2",   OP_LUI,  6'h00,  0, 2, 0, 6, 1, 0, 0};
        tbl[11] = '{"addm_d1",  OP_R,    F_ADDM, 0, 0, 1, 6, 1, 0, 0};
        tbl[12] = '{"sb_f1",    OP_SB,   6'h00,  0, 1, 0, 5, 0, 0, 0};

        pool = '{{OP_R, F_ADD}, {OP_R, F_SUB}, {OP_R, F_AND}, {OP_R, F_OR}, {OP_R, F_XOR},
                 {OP_R, F_NOR}, {OP_R, F_SLT}, {OP_R, F_JR}, {OP_R, F_ADDM}, {OP_R, 6'h11},
                 {OP_J, 6'h00}, {OP_BEQ, 6'h00}, {OP_BNE, 6'h00}, {OP_SLTI, 6'h00},
                 {OP_ORI, 6'h00}, {OP_LUI, 6'h00}, {OP_LBU, 6'h00}, {OP_SB, 6'h00},
                 {OP_SW, 6'h00}, {OP_ILL1, 6'h00}};

        // Reset state
        #3 chk_out("reset_outputs", out_t'(0));
        release_reset();

        // Directed vector table
        foreach (tbl[k]) begin
            run_instr(tbl[k].op, tbl[k].fn, tbl[k].z, tbl[k].flat, tbl[k].mlat);
            chk_int({tbl[k].nm, ".cycles"}, cyc, tbl[k].cyc);
            chk_int({tbl[k].nm, ".writeenable"}, wes, tbl[k].we);
            chk_int({tbl[k].nm, ".except"}, excs, tbl[k].exc);
            chk_int({tbl[k].nm, ".control_type"}, ct, tbl[k].ct);
        end

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            logic [11:0] pick;
            pick = pool[$urandom_range(19, 0)];
            run_instr(pick[11:6], pick[5:0], 1'($urandom), $urandom_range(3, 0), $urandom_range(3, 0));
            chk_int("rand.pc_updates", (ct >= 0) ? 1 : 0, 1);
        end

        // sb with memory never ready
        opcode = OP_SB; funct = '0; mem_ready = 1'b1;
        e = '0; e.mem_read = 1; e.ir_we = 1; step(e, "sbhang.fetch");
        e = '0; e.state = 3'd1; step(e, "sbhang.decode");
        mem_ready = 1'b0;
        e = '0; e.state = 3'd2; e.alu_src2 = 1; step(e, "sbhang.exec");
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            e = '0; e.state = 3'd3; e.byte_we = 1; step(e, "sbtmo.wait");
        end
        e = '0; e.state = 3'd3; e.except = 1; e.pc_we = 1; step(e, "sbtmo.abort");
`else
        for (int i = 0; i < 100; i++) begin
            e = '0; e.state = 3'd3; e.byte_we = 1; step(e, "sbhang.wait");
        end
        mem_ready = 1'b1;
        e = '0; e.state = 3'd3; e.byte_we = 1; e.pc_we = 1; step(e, "sbhang.done");
`endif
        run_instr(OP_R, F_ADD, 0, 0, 0);
        chk_int("after_sb.writeenable", wes, 1);

        // Asynchronous reset during the MEM phase of addm
        opcode = OP_R; funct = F_ADDM; mem_ready = 1'b1;
        e = '0; e.mem_read = 1; e.ir_we = 1; step(e, "rst.fetch");
        e = '0; e.state = 3'd1; step(e, "rst.decode");
        mem_ready = 1'b0;
        e = '0; e.state = 3'd2; step(e, "rst.exec");
        #1;
        e = '0; e.state = 3'd3; e.mem_read = 1; chk_out("rst.mem", e);
        #2 reset = 1'b0;
        #1 chk_out("rst.async_clear", out_t'(0));
        mem_ready = 1'b1;
        @(negedge clock);
        #1 chk_out("rst.held", out_t'(0));
        release_reset();
        run_instr(OP_R, F_ADD, 0, 0, 0);
        chk_int("rst.fresh_cycles", cyc, 4);
        chk_int("rst.fresh_writeenable", wes, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
